reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Parametrised in-order commit queue for the out-of-order RV32I core. Successor to the fixed 16-entry ROB:
- Depth, data width, opcode width and branch-predictor hash width are parameters.
- Occupancy is tracked with a counter, so every slot is usable.
- Commit sequencing (register writeback, store and IO-load memory handshakes, branch resolution) is a 3-state FSM.
- A mispredict produces a one-cycle flush pulse.
- Sits between decoder/fetcher (allocate), ALU/LSB CDBs (complete), register file, memory controller and branch predictor (commit).

## Interface
Parameters:
- DEPTH, 16: number of entries; tags 1..DEPTH, tag 0 means "none".
- TAG_W, $clog2(DEPTH+1): tag width.
- XLEN, 32: data/address width.
- OP_W, 6: opcode-enum width.
- BP_W, 8: predictor index width, taken from pc[BP_W+1:2].

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global stall; when 0 all state holds.
- alloc_valid  in  1  allocate one entry this cycle.
- alloc_op  in  OP_W  opcode enum; NOP is never allocated.
- alloc_dest  in  XLEN  destination register index in [4:0].
- alloc_pc  in  XLEN  instruction PC.
- alloc_pred  in  1  predicted-taken flag.
- alloc_tag  out  TAG_W  tag the next allocation receives; 0 when full.
- can_alloc  out  1  count <= DEPTH-2; fetcher throttle.
- rd_tag1 / rd_tag2  in  TAG_W  operand lookup tags.
- rd_val1 / rd_val2  out  XLEN  combinational entry values.
- rd_rdy1 / rd_rdy2  out  1  combinational entry ready bits.
- alu_tag  in  TAG_W  ALU completion; 0 means idle.
- alu_value, alu_newpc  in  XLEN  ALU result and target.
- lsb_tag  in  TAG_W  LSB completion.
- lsb_value, lsb_addr  in  XLEN  LSB result and address.
- lsb_io  in  1  completion is a deferred IO load.
- chk_addr  in  XLEN  LSB load address under test.
- chk_conflict  out  1  some valid uncommitted store has a resolved addr == chk_addr.
- wb_idx  out  5  commit register index; reset 0.
- wb_tag  out  TAG_W  commit tag; reset 0.
- wb_value  out  XLEN  commit value; reset 0.
- mem_req  out  1  store request pulse; reset 0.
- mem_load  out  1  IO-load request pulse; reset 0.
- mem_size  out  3  1, 2 or 4 bytes; reset 0.
- mem_addr, mem_data  out  XLEN  reset 0.
- mem_done  in  1  memory completion.
- mem_rdata  in  XLEN  IO-load data.
- bp_valid  out  1  predictor update pulse; reset 0.
- bp_idx  out  BP_W  predictor index; reset 0.
- bp_taken  out  1  actual outcome; reset 0.
- flush  out  1  mispredict/JALR redirect pulse; reset 0.
- flush_pc  out  XLEN  redirect target; reset 0.
- bc_tag  out  TAG_W  IO-load broadcast tag; reset 0.
- bc_value  out  XLEN  IO-load broadcast value; reset 0.
- count  out  TAG_W  occupancy; reset 0.

## Operation
- Entry fields: op, dest, pc, pred, value, newpc, ready, is_store, is_io.
- Pointers head (oldest) and tail (next free) run 1..DEPTH and wrap DEPTH→1.
- Allocate when alloc_valid and count<DEPTH: write fields, clear ready and value, set is_store for SB/SH/SW, advance tail. Allocate while full is ignored.
- ALU CDB: value, newpc, ready=1.
- LSB CDB: value; ready=!lsb_io; is_io=lsb_io. Stores also latch dest=lsb_addr.
- ALU and LSB tags are distinct by construction. Same-tag allocate+CDB cannot occur.
- FSM states: IDLE, WAIT_MEM, FLUSH. Head is evaluated in IDLE when count>0.
- Head ready, ALU/load op: wb_* pulse for one cycle; retire.
- Head ready, branch:
  - bp_valid pulse; bp_taken = value[0].
  - Outcome differs from pred: flush=1, flush_pc = newpc if taken else pc+4, go to FLUSH.
  - Always retire.
- Head ready, JALR: wb_* pulse, flush=1, flush_pc=newpc, retire, go to FLUSH.
- Head ready, store: mem_req pulse with size/addr/data; go to WAIT_MEM. On mem_done: retire, clear is_store, return to IDLE.
- Head is_io and not ready: mem_load pulse; go to WAIT_MEM. On mem_done:
  - wb_* and bc_* carry mem_rdata; entry becomes ready; retire; IDLE.
- FLUSH (one cycle): clear all valid/ready/is_store/is_io; head=tail=1; count=0; ignore alloc and CDB; then IDLE.
- Retire: head advances, count decrements. Allocate and retire in the same cycle leave count unchanged.
- Pulsed outputs (wb_idx, wb_tag, mem_req, mem_load, bp_valid, flush, bc_tag) default to 0 every non-stalled cycle.

## Timing
- Commit latency: 1 cycle from head ready (registered) to wb_* pulse.
- CDB-to-commit minimum: 2 cycles.
- rd_*, alloc_tag, can_alloc and chk_conflict are combinational from current state.
- A CDB write is visible on rd_* the next cycle.
- mem_done is honoured only in WAIT_MEM; spurious pulses are ignored.
- rst is asynchronous mid-operation: all outputs go to reset values immediately; memory requests are abandoned.
- rdy=0 freezes all state and outputs.

## Structure
- Shared package holds:
  - OPENUM constants (NOP, JALR, branches, SB/SH/SW).
  - JUMP_ENABLE and NEXT_PC (4).
  - ZERO tag/word.
  - FSM state encodings.
- Sub-module store_conflict_cam(DEPTH, XLEN): parallel compare of chk_addr against store entries. Replaces the hand-unrolled OR chain.

## Test plan
- Fill to DEPTH=4 with ADDIs, no CDB: alloc_tag becomes 0 and count=4. A 5th alloc is ignored. After CDBs on tags 1..4, four consecutive wb pulses in tag order 1,2,3,4; head wraps to 1.
- BEQ pred=0, alu value=1, newpc=0x100: bp_valid with bp_taken=1, flush=1, flush_pc=0x100. The next cycle count=0 and alloc_tag=1.
- SW at head, lsb_addr=0x40, value=0x1234: mem_req with size 4, addr 0x40, data 0x1234. chk_addr=0x40 gives conflict=1 until mem_done, then 0.
- IO load via lsb_io=1, mem_rdata=0xAB: mem_load pulse, then wb_value=0xAB and bc_tag=head tag.
- Simultaneous alloc and retire at count=DEPTH: count stays DEPTH and the new entry takes the freed slot.
- Assert rst during WAIT_MEM: all outputs return to 0 asynchronously, and the first post-reset alloc gets tag 1.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: opcode enum values, commit FSM
// encodings and small opcode-decode helpers.
package reorder_buffer_pkg;

    // Opcode enum values as produced by the decoder (NOP is never allocated).
    localparam int OP_NOP   = 0;
    localparam int OP_LUI   = 1;
    localparam int OP_AUIPC = 2;
    localparam int OP_JAL   = 3;
    localparam int OP_JALR  = 4;
    localparam int OP_BEQ   = 5;
    localparam int OP_BNE   = 6;
    localparam int OP_BLT   = 7;
    localparam int OP_BGE   = 8;
    localparam int OP_BLTU  = 9;
    localparam int OP_BGEU  = 10;
    localparam int OP_LB    = 11;
    localparam int OP_LH    = 12;
    localparam int OP_LW    = 13;
    localparam int OP_LBU   = 14;
    localparam int OP_LHU   = 15;
    localparam int OP_SB    = 16;
    localparam int OP_SH    = 17;
    localparam int OP_SW    = 18;
    localparam int OP_ADDI  = 19;

    // JALR always redirects fetch at commit when enabled.
    localparam logic JUMP_ENABLE = 1'b1;
    // Fall-through distance for a not-taken branch.
    localparam int NEXT_PC = 4;

    localparam int          ZERO_TAG  = 0;
    localparam logic [31:0] ZERO_WORD = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_FLUSH    = 2'd2
    } rob_state_t;

    function automatic logic op_is_branch(input int op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic op_is_store(input int op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Access size in bytes for loads and stores.
    function automatic logic [2:0] op_mem_size(input int op);
        case (op)
            OP_SB, OP_LB, OP_LBU: return 3'd1;
            OP_SH, OP_LH, OP_LHU: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/reorder_buffer_store_conflict_cam.sv
// Parallel match of a load address against every resolved, uncommitted store.
module store_conflict_cam #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32
) (
    input  logic [DEPTH:0]     valid,
    input  logic [DEPTH:0]     is_store,
    input  logic [DEPTH:0]     ready,
    input  logic [XLEN-1:0]    addr [0:DEPTH],
    input  logic [XLEN-1:0]    chk_addr,
    output logic               conflict
);
    logic [DEPTH:0] hit;

    // Slot 0 is never valid, so including it keeps the vectors uniform.
    generate
        for (genvar gi = 0; gi <= DEPTH; gi++) begin : g_cmp
            assign hit[gi] = valid[gi] & is_store[gi] & ready[gi] & (addr[gi] == chk_addr);
        end
    endgenerate

    assign conflict = |hit;
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocate at tail, complete from two CDBs, commit at
// head through a three-state FSM (idle / memory wait / flush).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH + 1),
    parameter int XLEN  = 32,
    parameter int OP_W  = 6,
    parameter int BP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic [OP_W-1:0]  alloc_op,
    input  logic [XLEN-1:0]  alloc_dest,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             alloc_pred,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             can_alloc,
    input  logic [TAG_W-1:0] rd_tag1,
    input  logic [TAG_W-1:0] rd_tag2,
    output logic [XLEN-1:0]  rd_val1,
    output logic [XLEN-1:0]  rd_val2,
    output logic             rd_rdy1,
    output logic             rd_rdy2,
    input  logic [TAG_W-1:0] alu_tag,
    input  logic [XLEN-1:0]  alu_value,
    input  logic [XLEN-1:0]  alu_newpc,
    input  logic [TAG_W-1:0] lsb_tag,
    input  logic [XLEN-1:0]  lsb_value,
    input  logic [XLEN-1:0]  lsb_addr,
    input  logic             lsb_io,
    input  logic [XLEN-1:0]  chk_addr,
    output logic             chk_conflict,
    output logic [4:0]       wb_idx,
    output logic [TAG_W-1:0] wb_tag,
    output logic [XLEN-1:0]  wb_value,
    output logic             mem_req,
    output logic             mem_load,
    output logic [2:0]       mem_size,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_data,
    input  logic             mem_done,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             bp_valid,
    output logic [BP_W-1:0]  bp_idx,
    output logic             bp_taken,
    output logic             flush,
    output logic [XLEN-1:0]  flush_pc,
    output logic [TAG_W-1:0] bc_tag,
    output logic [XLEN-1:0]  bc_value,
    output logic [TAG_W-1:0] count
);
    // Entries are indexed directly by tag; slot 0 ("no tag") stays empty.
    logic [OP_W-1:0]  op_reg    [0:DEPTH];
    logic [XLEN-1:0]  dest_reg  [0:DEPTH];
    logic [XLEN-1:0]  pc_reg    [0:DEPTH];
    logic [XLEN-1:0]  value_reg [0:DEPTH];
    logic [XLEN-1:0]  newpc_reg [0:DEPTH];
    logic [DEPTH:0]   pred_reg, ready_reg, store_reg, io_reg, valid_reg;
    logic [TAG_W-1:0] head_reg, tail_reg, count_reg;
    rob_state_t       state_reg, state_next;

    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(DEPTH)) ? TAG_W'(1) : p + TAG_W'(1);
    endfunction

    // Head entry decode shared by the next-state and output processes.
    logic [OP_W-1:0] h_op;
    logic [XLEN-1:0] h_dest, h_pc, h_value, h_newpc;
    logic            h_ready, h_pred, h_store, h_io, h_busy, h_branch, h_jalr;
    logic            cmt_branch, cmt_jalr, cmt_store, cmt_wb, cmt_ioreq, mispredict;
    logic            mem_fin, retire, io_done, alloc_ok;

    assign h_op     = op_reg[head_reg];
    assign h_dest   = dest_reg[head_reg];
    assign h_pc     = pc_reg[head_reg];
    assign h_value  = value_reg[head_reg];
    assign h_newpc  = newpc_reg[head_reg];
    assign h_ready  = ready_reg[head_reg];
    assign h_pred   = pred_reg[head_reg];
    assign h_store  = store_reg[head_reg];
    assign h_io     = io_reg[head_reg];
    assign h_busy   = (state_reg == ST_IDLE) && (count_reg != '0);
    assign h_branch = op_is_branch(int'(h_op));
    assign h_jalr   = JUMP_ENABLE && (int'(h_op) == OP_JALR);

    assign cmt_branch = h_busy && h_ready && h_branch;
    assign cmt_jalr   = h_busy && h_ready && !h_branch && h_jalr;
    assign cmt_store  = h_busy && h_ready && !h_branch && !h_jalr && h_store;
    assign cmt_wb     = h_busy && h_ready && !h_branch && !h_jalr && !h_store;
    assign cmt_ioreq  = h_busy && !h_ready && h_io;
    assign mispredict = h_value[0] != h_pred;
    assign mem_fin    = (state_reg == ST_WAIT_MEM) && mem_done;
    assign io_done    = mem_fin && !h_store;
    assign retire     = cmt_branch || cmt_jalr || cmt_wb || mem_fin;
    // A retiring head frees a slot in the same cycle, so a full queue may still accept.
    assign alloc_ok   = alloc_valid && ((count_reg < TAG_W'(DEPTH)) || retire);

    assign alloc_tag = (count_reg == TAG_W'(DEPTH)) ? TAG_W'(ZERO_TAG) : tail_reg;
    assign can_alloc = int'(count_reg) <= DEPTH - 2;
    assign rd_val1   = value_reg[rd_tag1];
    assign rd_val2   = value_reg[rd_tag2];
    assign rd_rdy1   = ready_reg[rd_tag1];
    assign rd_rdy2   = ready_reg[rd_tag2];
    assign count     = count_reg;

    store_conflict_cam #(.DEPTH(DEPTH), .XLEN(XLEN)) u_cam (
        .valid    (valid_reg),
        .is_store (store_reg),
        .ready    (ready_reg),
        .addr     (dest_reg),
        .chk_addr (chk_addr),
        .conflict (chk_conflict)
    );

    // Commit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state_reg <= ST_IDLE;
        else if (rdy) state_reg <= state_next;
    end

    // Commit FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if ((cmt_branch && mispredict) || cmt_jalr) state_next = ST_FLUSH;
                else if (cmt_store || cmt_ioreq)            state_next = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: if (mem_done) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    logic [4:0]       wb_idx_next;
    logic [TAG_W-1:0] wb_tag_next, bc_tag_next;
    logic [XLEN-1:0]  wb_value_next, mem_addr_next, mem_data_next, flush_pc_next, bc_value_next;
    logic             mem_req_next, mem_load_next, bp_valid_next, bp_taken_next, flush_next;
    logic [2:0]       mem_size_next;
    logic [BP_W-1:0]  bp_idx_next;

    // Commit FSM outputs: pulses default low, data outputs hold their last value.
    always_comb begin
        wb_idx_next   = '0;
        wb_tag_next   = '0;
        bc_tag_next   = '0;
        mem_req_next  = 1'b0;
        mem_load_next = 1'b0;
        bp_valid_next = 1'b0;
        flush_next    = 1'b0;
        wb_value_next = wb_value;
        mem_size_next = mem_size;
        mem_addr_next = mem_addr;
        mem_data_next = mem_data;
        bp_idx_next   = bp_idx;
        bp_taken_next = bp_taken;
        flush_pc_next = flush_pc;
        bc_value_next = bc_value;
        if (cmt_branch) begin
            bp_valid_next = 1'b1;
            bp_idx_next   = h_pc[BP_W+1:2];
            bp_taken_next = h_value[0];
            if (mispredict) begin
                flush_next    = 1'b1;
                flush_pc_next = h_value[0] ? h_newpc : h_pc + XLEN'(NEXT_PC);
            end
        end
        if (cmt_jalr || cmt_wb) begin
            wb_idx_next   = h_dest[4:0];
            wb_tag_next   = head_reg;
            wb_value_next = h_value;
        end
        if (cmt_jalr) begin
            flush_next    = 1'b1;
            flush_pc_next = h_newpc;
        end
        if (cmt_store || cmt_ioreq) begin
            mem_req_next  = cmt_store;
            mem_load_next = cmt_ioreq;
            mem_size_next = op_mem_size(int'(h_op));
            // Stores keep their address in dest; IO loads keep it in newpc.
            mem_addr_next = cmt_store ? h_dest : h_newpc;
            mem_data_next = h_value;
        end
        if (io_done) begin
            wb_idx_next   = h_dest[4:0];
            wb_tag_next   = head_reg;
            wb_value_next = mem_rdata;
            bc_tag_next   = head_reg;
            bc_value_next = mem_rdata;
        end
    end

    // Registered commit outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_idx   <= '0;                  wb_tag   <= TAG_W'(ZERO_TAG);
            wb_value <= XLEN'(ZERO_WORD);    mem_req  <= 1'b0;
            mem_load <= 1'b0;                mem_size <= '0;
            mem_addr <= XLEN'(ZERO_WORD);    mem_data <= XLEN'(ZERO_WORD);
            bp_valid <= 1'b0;                bp_idx   <= '0;
            bp_taken <= 1'b0;                flush    <= 1'b0;
            flush_pc <= XLEN'(ZERO_WORD);    bc_tag   <= TAG_W'(ZERO_TAG);
            bc_value <= XLEN'(ZERO_WORD);
        end else if (rdy) begin
            wb_idx   <= wb_idx_next;         wb_tag   <= wb_tag_next;
            wb_value <= wb_value_next;       mem_req  <= mem_req_next;
            mem_load <= mem_load_next;       mem_size <= mem_size_next;
            mem_addr <= mem_addr_next;       mem_data <= mem_data_next;
            bp_valid <= bp_valid_next;       bp_idx   <= bp_idx_next;
            bp_taken <= bp_taken_next;       flush    <= flush_next;
            flush_pc <= flush_pc_next;       bc_tag   <= bc_tag_next;
            bc_value <= bc_value_next;
        end
    end

    // Entry storage, pointers and occupancy: retire, then allocate, then CDB writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                op_reg[i]    <= '0;
                dest_reg[i]  <= '0;
                pc_reg[i]    <= '0;
                value_reg[i] <= '0;
                newpc_reg[i] <= '0;
            end
            pred_reg  <= '0;
            ready_reg <= '0;
            store_reg <= '0;
            io_reg    <= '0;
            valid_reg <= '0;
            head_reg  <= TAG_W'(1);
            tail_reg  <= TAG_W'(1);
            count_reg <= '0;
        end else if (rdy) begin
            if (state_reg == ST_FLUSH) begin
                valid_reg <= '0;
                ready_reg <= '0;
                store_reg <= '0;
                io_reg    <= '0;
                head_reg  <= TAG_W'(1);
                tail_reg  <= TAG_W'(1);
                count_reg <= '0;
            end else begin
                if (retire) begin
                    valid_reg[head_reg] <= 1'b0;
                    store_reg[head_reg] <= 1'b0;
                    io_reg[head_reg]    <= 1'b0;
                    if (io_done) begin
                        ready_reg[head_reg] <= 1'b1;
                        value_reg[head_reg] <= mem_rdata;
                    end
                    head_reg <= wrap_inc(head_reg);
                end
                if (alloc_ok) begin
                    op_reg[tail_reg]    <= alloc_op;
                    dest_reg[tail_reg]  <= alloc_dest;
                    pc_reg[tail_reg]    <= alloc_pc;
                    pred_reg[tail_reg]  <= alloc_pred;
                    value_reg[tail_reg] <= '0;
                    ready_reg[tail_reg] <= 1'b0;
                    store_reg[tail_reg] <= op_is_store(int'(alloc_op));
                    io_reg[tail_reg]    <= 1'b0;
                    valid_reg[tail_reg] <= 1'b1;
                    tail_reg            <= wrap_inc(tail_reg);
                end
                if (alu_tag != '0) begin
                    value_reg[alu_tag] <= alu_value;
                    newpc_reg[alu_tag] <= alu_newpc;
                    ready_reg[alu_tag] <= 1'b1;
                end
                if (lsb_tag != '0) begin
                    value_reg[lsb_tag] <= lsb_value;
                    newpc_reg[lsb_tag] <= lsb_addr;
                    ready_reg[lsb_tag] <= !lsb_io;
                    io_reg[lsb_tag]    <= lsb_io;
                    if (store_reg[lsb_tag]) dest_reg[lsb_tag] <= lsb_addr;
                end
                count_reg <= count_reg + TAG_W'(alloc_ok) - TAG_W'(retire);
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (DEPTH=4) with a writeback scoreboard.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;
    localparam int XLEN  = 32;
    localparam int OP_W  = 6;
    localparam int BP_W  = 8;

    logic clk = 1'b0;
    logic rst, rdy;
    logic alloc_valid, alloc_pred, can_alloc, lsb_io, chk_conflict;
    logic [OP_W-1:0]  alloc_op;
    logic [XLEN-1:0]  alloc_dest, alloc_pc;
    logic [TAG_W-1:0] alloc_tag, rd_tag1, rd_tag2, alu_tag, lsb_tag, wb_tag, bc_tag, count;
    logic [XLEN-1:0]  rd_val1, rd_val2, alu_value, alu_newpc, lsb_value, lsb_addr, chk_addr;
    logic             rd_rdy1, rd_rdy2;
    logic [4:0]       wb_idx;
    logic [XLEN-1:0]  wb_value, mem_addr, mem_data, mem_rdata, flush_pc, bc_value;
    logic             mem_req, mem_load, mem_done, bp_valid, bp_taken, flush;
    logic [2:0]       mem_size;
    logic [BP_W-1:0]  bp_idx;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [4:0]       idx;
        logic [XLEN-1:0]  value;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W), .BP_W(BP_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_dest(alloc_dest),
        .alloc_pc(alloc_pc), .alloc_pred(alloc_pred), .alloc_tag(alloc_tag), .can_alloc(can_alloc),
        .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_val1(rd_val1), .rd_val2(rd_val2),
        .rd_rdy1(rd_rdy1), .rd_rdy2(rd_rdy2),
        .alu_tag(alu_tag), .alu_value(alu_value), .alu_newpc(alu_newpc),
        .lsb_tag(lsb_tag), .lsb_value(lsb_value), .lsb_addr(lsb_addr), .lsb_io(lsb_io),
        .chk_addr(chk_addr), .chk_conflict(chk_conflict),
        .wb_idx(wb_idx), .wb_tag(wb_tag), .wb_value(wb_value),
        .mem_req(mem_req), .mem_load(mem_load), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .bp_valid(bp_valid), .bp_idx(bp_idx), .bp_taken(bp_taken),
        .flush(flush), .flush_pc(flush_pc), .bc_tag(bc_tag), .bc_value(bc_value), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic push_exp(input int tag, input int idx, input logic [31:0] value);
        exp_t e;
        e.tag = TAG_W'(tag);
        e.idx = 5'(idx);
        e.value = value;
        sb_q.push_back(e);
    endtask

    // Advance one clock, sample after the edge, and match any writeback pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        $display("t=%0t tag=%0d wb_tag=%0d wb_val=0x%0h count=%0d flush=%0b mem_req=%0b mem_load=%0b",
                 $time, alloc_tag, wb_tag, wb_value, count, flush, mem_req, mem_load);
        if (wb_tag !== '0) begin
            chk("wb_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("wb_tag", 32'(wb_tag), 32'(e.tag));
                chk("wb_idx", 32'(wb_idx), 32'(e.idx));
                chk("wb_value", wb_value, e.value);
            end
        end
    endtask

    task automatic do_alloc(input int op, input int dest, input int pc, input logic pred);
        alloc_valid = 1'b1;
        alloc_op    = OP_W'(op);
        alloc_dest  = 32'(dest);
        alloc_pc    = 32'(pc);
        alloc_pred  = pred;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic alu_cdb(input int tag, input logic [31:0] value, input logic [31:0] newpc);
        alu_tag   = TAG_W'(tag);
        alu_value = value;
        alu_newpc = newpc;
        tick();
        alu_tag = '0;
    endtask

    task automatic lsb_cdb(input int tag, input logic [31:0] value, input logic [31:0] addr, input logic io);
        lsb_tag   = TAG_W'(tag);
        lsb_value = value;
        lsb_addr  = addr;
        lsb_io    = io;
        tick();
        lsb_tag = '0;
        lsb_io  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        alloc_valid = 1'b0; alloc_op = '0; alloc_dest = '0; alloc_pc = '0; alloc_pred = 1'b0;
        rd_tag1 = '0; rd_tag2 = '0;
        alu_tag = '0; alu_value = '0; alu_newpc = '0;
        lsb_tag = '0; lsb_value = '0; lsb_addr = '0; lsb_io = 1'b0;
        chk_addr = '0; mem_done = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd1);
        chk("rst_can_alloc", 32'(can_alloc), 32'd1);
        chk("rst_wb_tag", 32'(wb_tag), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);

        // Fill with four ADDIs; no completions yet.
        for (int i = 1; i <= DEPTH; i++) begin
            do_alloc(OP_ADDI, i, 4 * (i - 1), 1'b0);
            if (i == 2) chk("can_alloc_at2", 32'(can_alloc), 32'd1);
            if (i == 3) chk("can_alloc_at3", 32'(can_alloc), 32'd0);
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_alloc_tag", 32'(alloc_tag), 32'd0);
        mem_done = 1'b1;
        do_alloc(OP_ADDI, 9, 32'h10, 1'b0);
        mem_done = 1'b0;
        chk("full_ignore_count", 32'(count), 32'd4);
        rd_tag1 = 3'd1; rd_tag2 = 3'd2;
        #1 chk("rd_rdy1_before", 32'(rd_rdy1), 32'd0);

        // Complete tags 1..4 back to back; commits follow in tag order.
        for (int i = 1; i <= DEPTH; i++) begin
            push_exp(i, i, 32'h100 + 32'(i));
            alu_cdb(i, 32'h100 + 32'(i), 32'h0);
            if (i == 1) begin
                chk("rd_val1", rd_val1, 32'h101);
                chk("rd_rdy1", 32'(rd_rdy1), 32'd1);
                chk("rd_rdy2", 32'(rd_rdy2), 32'd0);
            end
        end
        repeat (3) tick();
        chk("fill_drain", 32'(sb_q.size()), 32'd0);
        chk("fill_count", 32'(count), 32'd0);
        chk("wrap_alloc_tag", 32'(alloc_tag), 32'd1);

        // Wrapped head commits tag 1 again.
        do_alloc(OP_ADDI, 5, 32'h14, 1'b0);
        push_exp(1, 5, 32'h55);
        alu_cdb(1, 32'h55, 32'h0);
        repeat (2) tick();
        chk("wrap_drain", 32'(sb_q.size()), 32'd0);

        // Mispredicted BEQ (tag 2): predicted not-taken, resolves taken.
        do_alloc(OP_BEQ, 0, 32'h20, 1'b0);
        alu_cdb(2, 32'h1, 32'h100);
        tick();
        chk("br_bp_valid", 32'(bp_valid), 32'd1);
        chk("br_bp_taken", 32'(bp_taken), 32'd1);
        chk("br_bp_idx", 32'(bp_idx), 32'h8);
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_flush_pc", flush_pc, 32'h100);
        tick();
        chk("br_post_count", 32'(count), 32'd0);
        chk("br_post_alloc_tag", 32'(alloc_tag), 32'd1);
        chk("br_post_flush", 32'(flush), 32'd0);

        // Store word at head (tag 1).
        chk_addr = 32'h40;
        do_alloc(OP_SW, 0, 32'h30, 1'b0);
        chk("st_conflict_unresolved", 32'(chk_conflict), 32'd0);
        lsb_cdb(1, 32'h1234, 32'h40, 1'b0);
        chk("st_conflict", 32'(chk_conflict), 32'd1);
        chk_addr = 32'h44;
        #1 chk("st_conflict_other", 32'(chk_conflict), 32'd0);
        chk_addr = 32'h40;
        tick();
        chk("st_mem_req", 32'(mem_req), 32'd1);
        chk("st_mem_size", 32'(mem_size), 32'd4);
        chk("st_mem_addr", mem_addr, 32'h40);
        chk("st_mem_data", mem_data, 32'h1234);
        tick();
        chk("st_mem_req_pulse", 32'(mem_req), 32'd0);
        chk("st_conflict_wait", 32'(chk_conflict), 32'd1);
        rdy = 1'b0; mem_done = 1'b1;
        tick();
        chk("stall_count", 32'(count), 32'd1);
        chk("stall_conflict", 32'(chk_conflict), 32'd1);
        rdy = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("st_done_conflict", 32'(chk_conflict), 32'd0);
        chk("st_done_count", 32'(count), 32'd0);

        // Deferred IO load (tag 2) into x7.
        do_alloc(OP_LW, 7, 32'h34, 1'b0);
        lsb_cdb(2, 32'h0, 32'h3000, 1'b1);
        tick();
        chk("io_mem_load", 32'(mem_load), 32'd1);
        chk("io_mem_size", 32'(mem_size), 32'd4);
        push_exp(2, 7, 32'hAB);
        mem_done = 1'b1; mem_rdata = 32'hAB;
        tick();
        mem_done = 1'b0;
        chk("io_bc_tag", 32'(bc_tag), 32'd2);
        chk("io_bc_value", bc_value, 32'hAB);
        chk("io_count", 32'(count), 32'd0);
        tick();
        chk("io_bc_pulse", 32'(bc_tag), 32'd0);
        chk("io_drain", 32'(sb_q.size()), 32'd0);

        // Full queue: allocate in the same cycle the head retires.
        for (int i = 0; i < DEPTH; i++) do_alloc(OP_ADDI, 10 + i, 32'h100 + 32'(4 * i), 1'b0);
        chk("full2_count", 32'(count), 32'd4);
        push_exp(3, 10, 32'h33);
        alu_cdb(3, 32'h33, 32'h0);
        chk("full2_alloc_tag", 32'(alloc_tag), 32'd0);
        do_alloc(OP_ADDI, 9, 32'h200, 1'b0);
        chk("full2_same_count", 32'(count), 32'd4);
        push_exp(4, 11, 32'h44); alu_cdb(4, 32'h44, 32'h0);
        push_exp(1, 12, 32'h11); alu_cdb(1, 32'h11, 32'h0);
        push_exp(2, 13, 32'h22); alu_cdb(2, 32'h22, 32'h0);
        push_exp(3, 9, 32'h99);  alu_cdb(3, 32'h99, 32'h0);
        repeat (3) tick();
        chk("full2_drain", 32'(sb_q.size()), 32'd0);
        chk("full2_end_count", 32'(count), 32'd0);

        // Asynchronous reset while a store waits on memory.
        chk("pre_rst_alloc_tag", 32'(alloc_tag), 32'd4);
        do_alloc(OP_SW, 0, 32'h40, 1'b0);
        lsb_cdb(4, 32'h99, 32'h80, 1'b0);
        tick();
        chk("rst_st_mem_addr", mem_addr, 32'h80);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_data", mem_data, 32'h0);
        chk("arst_mem_size", 32'(mem_size), 32'd0);
        chk("arst_wb_value", wb_value, 32'h0);
        chk("arst_count", 32'(count), 32'd0);
        tick();
        rst = 1'b0;
        chk("post_rst_alloc_tag", 32'(alloc_tag), 32'd1);
        do_alloc(OP_ADDI, 3, 32'h300, 1'b0);
        chk("post_rst_count", 32'(count), 32'd1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("spurious_done_count", 32'(count), 32'd1);
        push_exp(1, 3, 32'h77);
        alu_cdb(1, 32'h77, 32'h0);
        repeat (2) tick();
        chk("post_rst_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
